// File: rtl/sdram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_pkg
//   Shared definitions for the SDRAM arbiter slice:
//   - SDRAM command encodings {CS_n,RAS_n,CAS_n,WE_n}
//   - default pin widths
//   - arbiter state encoding (3 bits)
// -----------------------------------------------------------------------------
package sdram_arbiter_pkg;

    // Default SDRAM pin widths.
    localparam int SDR_ADDR_BITS = 12;
    localparam int SDR_BA_BITS   = 2;

    // SDRAM commands, {CS_n,RAS_n,CAS_n,WE_n}.
    localparam logic [3:0] SDR_CMD_NOP  = 4'b0111;
    localparam logic [3:0] SDR_CMD_PRE  = 4'b0010;
    localparam logic [3:0] SDR_CMD_AREF = 4'b0001;
    localparam logic [3:0] SDR_CMD_ACT  = 4'b0011;
    localparam logic [3:0] SDR_CMD_RD   = 4'b0101;
    localparam logic [3:0] SDR_CMD_WR   = 4'b0100;
    localparam logic [3:0] SDR_CMD_LMR  = 4'b0000;

    // Arbiter states. Encodings 5..7 are illegal and recover to ARB_IDLE.
    typedef enum logic [2:0] {
        ARB_INIT  = 3'd0,
        ARB_IDLE  = 3'd1,
        ARB_AREF  = 3'd2,
        ARB_WRITE = 3'd3,
        ARB_READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_cmd_mux.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_cmd_mux
//   State-indexed mux that puts the owning engine's command/address/bank on
//   the SDRAM pins. Purely combinational: no added command latency.
//   Ports:
//     state                        current arbiter state
//     init_cmd/init_addr           init engine (bank forced to 0)
//     aref_cmd                     refresh engine (address and bank forced to 0)
//     wr_cmd/wr_addr/wr_ba         write engine
//     rd_cmd/rd_addr/rd_ba         read engine
//     sdram_cmd/addr/ba            SDRAM pins
// -----------------------------------------------------------------------------
module sdram_arbiter_cmd_mux
    import sdram_arbiter_pkg::*;
#(
    parameter int         ADDR_BITS = SDR_ADDR_BITS,
    parameter int         BA_BITS   = SDR_BA_BITS,
    parameter logic [3:0] CMD_NOP   = SDR_CMD_NOP
) (
    input  arb_state_t           state,
    input  logic [3:0]           init_cmd,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [3:0]           aref_cmd,
    input  logic [3:0]           wr_cmd,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [BA_BITS-1:0]   wr_ba,
    input  logic [3:0]           rd_cmd,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [BA_BITS-1:0]   rd_ba,
    output logic [3:0]           sdram_cmd,
    output logic [ADDR_BITS-1:0] sdram_addr,
    output logic [BA_BITS-1:0]   sdram_ba
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
        case (state)
            ARB_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ARB_AREF: begin
                sdram_cmd  = aref_cmd;
            end
            ARB_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_ba   = wr_ba;
            end
            ARB_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: ; // IDLE and illegal encodings: NOP on the bus
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//   Sole owner of the SDRAM command/address pins. Arbitrates between the init,
//   auto-refresh, write and read engines, grants one at a time and muxes the
//   owner's command/address/bank onto the pins.
//   Ports:
//     sdram_clk, rst_n             clock, async active-low reset
//     init_done/cmd/addr           init engine
//     aref_req/cmd/done            refresh engine (req level, done pulse)
//     wr_req/cmd/addr/ba           write engine (req level)
//     go_aref_wr, wr_done_all      write engine yield / finish pulses
//     rd_req/cmd/addr/ba           read engine (req level)
//     go_aref_rd, rd_done_all      read engine yield / finish pulses
//     aref_en, wr_en, rd_en        grants
//     sdram_cmd/addr/ba            SDRAM pins
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int         ADDR_BITS = SDR_ADDR_BITS,
    parameter int         BA_BITS   = SDR_BA_BITS,
    parameter logic [3:0] CMD_NOP   = SDR_CMD_NOP
) (
    input  logic                 sdram_clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic [3:0]           init_cmd,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic                 aref_req,
    input  logic [3:0]           aref_cmd,
    input  logic                 aref_done,
    input  logic                 wr_req,
    input  logic [3:0]           wr_cmd,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [BA_BITS-1:0]   wr_ba,
    input  logic                 go_aref_wr,
    input  logic                 wr_done_all,
    input  logic                 rd_req,
    input  logic [3:0]           rd_cmd,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [BA_BITS-1:0]   rd_ba,
    input  logic                 go_aref_rd,
    input  logic                 rd_done_all,
    output logic                 aref_en,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [3:0]           sdram_cmd,
    output logic [ADDR_BITS-1:0] sdram_addr,
    output logic [BA_BITS-1:0]   sdram_ba
);

    arb_state_t state, next_state;
    logic       last_wr;   // 1 when the last IDLE decision went to the writer

    // State register and round-robin flag.
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_INIT;
            last_wr <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state <= next_state;
            if (state == ARB_IDLE) begin
                if (next_state == ARB_WRITE)
                    last_wr <= 1'b1;
                else if (next_state == ARB_READ)
                    last_wr <= 1'b0;
            end
        end
    end

    // Next-state logic and grants.
    always_comb begin
        next_state = state;
        aref_en    = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state)
            ARB_INIT: begin
                if (init_done)
                    next_state = ARB_IDLE;
            end
            ARB_IDLE: begin
                if (aref_req)
                    next_state = ARB_AREF;
                else if (wr_req && rd_req)
                    next_state = last_wr ? ARB_READ : ARB_WRITE;
                else if (wr_req)
                    next_state = ARB_WRITE;
                else if (rd_req)
                    next_state = ARB_READ;
            end
            ARB_AREF: begin
                aref_en = 1'b1;
                if (aref_done)
                    next_state = ARB_IDLE;
            end
            ARB_WRITE: begin
                // Grant drops on the yield/finish pulse cycle so the engine,
                // now back in its request state, cannot re-activate.
                wr_en = !go_aref_wr && !wr_done_all;
                if (go_aref_wr)
                    next_state = ARB_AREF;   // refresh wins over a coincident done
                else if (wr_done_all)
                    next_state = ARB_IDLE;
            end
            ARB_READ: begin
                rd_en = !go_aref_rd && !rd_done_all;
                if (go_aref_rd)
                    next_state = ARB_AREF;
                else if (rd_done_all)
                    next_state = ARB_IDLE;
            end
            default: next_state = ARB_IDLE;  // illegal encoding, no grants
        endcase
    end

    sdram_arbiter_cmd_mux #(
        .ADDR_BITS (ADDR_BITS),
        .BA_BITS   (BA_BITS),
        .CMD_NOP   (CMD_NOP)
    ) u_cmd_mux (
        .state      (state),
        .init_cmd   (init_cmd),
        .init_addr  (init_addr),
        .aref_cmd   (aref_cmd),
        .wr_cmd     (wr_cmd),
        .wr_addr    (wr_addr),
        .wr_ba      (wr_ba),
        .rd_cmd     (rd_cmd),
        .rd_addr    (rd_addr),
        .rd_ba      (rd_ba),
        .sdram_cmd  (sdram_cmd),
        .sdram_addr (sdram_addr),
        .sdram_ba   (sdram_ba)
    );

endmodule
